mem_access_unit: RTL and testbench

Data-side memory access unit sitting between the pipelined CPU memory stage and `dmem`. It handles the sub-word accesses that `dmem` cannot do natively:
- loads: byte and halfword extraction with sign or zero extension;
- stores: byte and halfword writes via a two-cycle read-modify-write, with a stall back to the CPU.

It also detects misaligned accesses and blocks the write for them.

---
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Data-side memory access unit between the CPU memory stage and dmem.
// Adds sub-word loads (byte/halfword with sign or zero extension) and
// sub-word stores (two-cycle read-modify-write with a one-cycle stall).
// Misaligned accesses never write and raise a sticky AlignFault.
//
// Ports:
//   CLK, Reset        clock, asynchronous active-low reset
//   MemWriteM         store request
//   MemReadM          load request
//   MemoryControl     [1:0] size (00 word, 01 byte, 10 half, 11 word),
//                     [2] 1 = zero-extend loads, 0 = sign-extend
//   ALUOutM           byte address
//   WriteDataM        store data, right-aligned for sub-word stores
//   ReadDataM         extended load data
//   StallM            holds the CPU pipeline during the RMW read cycle
//   AlignFault        sticky misalignment flag
//   WE, A, WD         dmem write enable, word address, write data
//   RD                dmem read data (combinational from A)
module mem_access_unit #(
  parameter int SIZE = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            MemWriteM,
  input  logic            MemReadM,
  input  logic [2:0]      MemoryControl,
  input  logic [SIZE-1:0] ALUOutM,
  input  logic [SIZE-1:0] WriteDataM,
  output logic [SIZE-1:0] ReadDataM,
  output logic            StallM,
  output logic            AlignFault,
  output logic            WE,
  output logic [SIZE-1:0] A,
  output logic [SIZE-1:0] WD,
  input  logic [SIZE-1:0] RD
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] merged_q, merged_d;
  logic            align_fault_q, align_fault_d;

  logic            is_byte, is_half, is_word, zext, misaligned, req;
  logic            we_raw, stall_raw;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic z);
    logic signed [7:0]  sb;
    logic signed [31:0] sw;
    sb = b;
    sw = sb;
    return z ? {24'b0, b} : sw;
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic z);
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    sh = h;
    sw = sh;
    return z ? {16'b0, h} : sw;
  endfunction

  // Replace one byte or halfword lane of the current dmem word.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  addr,
                                             input logic        half);
    logic [31:0] m;
    m = word;
    if (half) begin
      if (addr[1]) m[31:16] = data[15:0];
      else         m[15:0]  = data[15:0];
    end else begin
      case (addr)
        2'd0:    m[7:0]   = data[7:0];
        2'd1:    m[15:8]  = data[7:0];
        2'd2:    m[23:16] = data[7:0];
        default: m[31:24] = data[7:0];
      endcase
    end
    return m;
  endfunction

  assign is_byte    = (MemoryControl[1:0] == 2'b01);
  assign is_half    = (MemoryControl[1:0] == 2'b10);
  assign is_word    = !is_byte && !is_half;
  assign zext       = MemoryControl[2];
  assign misaligned = (is_word && (ALUOutM[1:0] != 2'b00)) || (is_half && ALUOutM[0]);
  assign req        = MemWriteM || MemReadM;

  assign A          = {ALUOutM[SIZE-1:2], 2'b00};
  assign byte_lane  = RD[8*ALUOutM[1:0] +: 8];
  assign half_lane  = ALUOutM[1] ? RD[31:16] : RD[15:0];

  always_comb begin
    if (misaligned)   ReadDataM = '0;
    else if (is_byte) ReadDataM = ext_byte(byte_lane, zext);
    else if (is_half) ReadDataM = ext_half(half_lane, zext);
    else              ReadDataM = RD;
  end

  always_comb begin
    state_d       = state_q;
    merged_d      = merged_q;
    align_fault_d = align_fault_q || (req && misaligned);
    we_raw        = 1'b0;
    stall_raw     = 1'b0;
    WD            = WriteDataM;
    case (state_q)
      IDLE: begin
        if (MemWriteM && !misaligned) begin
          if (is_word) begin
            we_raw = 1'b1;
          end else begin
            stall_raw = 1'b1;
            merged_d  = merge_lane(RD, WriteDataM, ALUOutM[1:0], is_half);
            state_d   = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        we_raw  = 1'b1;
        WD      = merged_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate with Reset so a pending request cannot write or stall while in reset.
  assign WE         = we_raw && Reset;
  assign StallM     = stall_raw && Reset;
  assign AlignFault = align_fault_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      merged_q      <= '0;
      align_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      merged_q      <= merged_d;
      align_fault_q <= align_fault_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        MemWriteM, MemReadM;
  logic [2:0]  MemoryControl;
  logic [31:0] ALUOutM, WriteDataM;
  logic [31:0] ReadDataM, A, WD, RD;
  logic        StallM, AlignFault, WE;

  int tests  = 0;
  int failed = 0;

  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (pl_en)   mem[pl_idx] <= pl_data;
    else if (WE) mem[A[7:2]] <= WD;
  end
  assign RD = mem[A[7:2]];

  mem_access_unit #(.SIZE(32)) dut (
    .CLK(CLK), .Reset(Reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .MemoryControl(MemoryControl), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .AlignFault(AlignFault),
    .WE(WE), .A(A), .WD(WD), .RD(RD)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  mc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic        exp_we;
    logic        exp_stall;
    logic        chk_wd;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [0:12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    after_edge();
    pl_en   = 1'b0;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [2:0] mc,
                       input logic [31:0] addr, input logic [31:0] wdata);
    MemWriteM     = wr;
    MemReadM      = rd;
    MemoryControl = mc;
    ALUOutM       = addr;
    WriteDataM    = wdata;
  endtask

  initial begin
    // wr rd mc addr wdata chk_rd exp_rdata exp_we exp_stall chk_wd exp_wd
    vecs[0]  = '{1'b0, 1'b1, 3'b001, 32'h21, 32'h0, 1'b1, 32'h0000007F, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 3'b001, 32'h23, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 3'b110, 32'h22, 32'h0, 1'b1, 32'h000080FF, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 1'b1, 32'h00007F01, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 3'b010, 32'h22, 32'h0, 1'b1, 32'hFFFF80FF, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 3'b101, 32'h20, 32'h0, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h22, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'b101, 32'h22, 32'h0, 1'b1, 32'h000000FF, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h20, 32'h0, 1'b1, 32'h80FF7F01, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 3'b111, 32'h20, 32'h0, 1'b1, 32'h80FF7F01, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 3'b001, 32'h20, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h24, 32'h55AA55AA, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h55AA55AA};
    vecs[12] = '{1'b1, 1'b1, 3'b100, 32'h28, 32'hA5A5A5A5, 1'b1, 32'h01234567, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5};

    // Reset with a pending word store
    Reset = 1'b0;
    drive(1'b1, 1'b0, 3'b000, 32'h10, 32'hDEADBEEF);
    preload(6'd4, 32'h0);
    after_edge();
    @(negedge CLK);
    check("rst_we", {31'b0, WE}, 32'd0);
    check("rst_stall", {31'b0, StallM}, 32'd0);
    check("rst_fault", {31'b0, AlignFault}, 32'd0);
    #2 Reset = 1'b1;
    #1;
    check("wst_we", {31'b0, WE}, 32'd1);
    check("wst_wd", WD, 32'hDEADBEEF);
    check("wst_stall", {31'b0, StallM}, 32'd0);
    after_edge();
    drive(1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
    check("wst_mem", mem[4], 32'hDEADBEEF);

    // Byte store read-modify-write
    preload(6'd4, 32'h11223344);
    drive(1'b1, 1'b0, 3'b001, 32'h12, 32'hCCCCCCAB);
    @(negedge CLK);
    check("bst_n_stall", {31'b0, StallM}, 32'd1);
    check("bst_n_we", {31'b0, WE}, 32'd0);
    after_edge();
    check("bst_n1_we", {31'b0, WE}, 32'd1);
    check("bst_n1_wd", WD, 32'h11AB3344);
    check("bst_n1_stall", {31'b0, StallM}, 32'd0);
    check("bst_n1_a", A, 32'h10);
    after_edge();
    drive(1'b0, 1'b1, 3'b000, 32'h10, 32'h0);
    @(negedge CLK);
    check("bst_load", ReadDataM, 32'h11AB3344);
    check("bst_load_we", {31'b0, WE}, 32'd0);

    // Single-cycle table vectors
    preload(6'd8, 32'h80FF7F01);
    preload(6'd10, 32'h01234567);
    for (int i = 0; i <= 12; i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].mc, vecs[i].addr, vecs[i].wdata);
      @(negedge CLK);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), ReadDataM, vecs[i].exp_rdata);
      check($sformatf("vec%0d_we", i), {31'b0, WE}, {31'b0, vecs[i].exp_we});
      check($sformatf("vec%0d_stall", i), {31'b0, StallM}, {31'b0, vecs[i].exp_stall});
      if (vecs[i].chk_wd) check($sformatf("vec%0d_wd", i), WD, vecs[i].exp_wd);
      check($sformatf("vec%0d_a", i), A, {vecs[i].addr[31:2], 2'b00});
      after_edge();
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("vec_mem24", mem[9], 32'h55AA55AA);
    check("vec_mem28", mem[10], 32'hA5A5A5A5);
    check("vec_fault", {31'b0, AlignFault}, 32'd0);

    // Misaligned word store
    preload(6'd12, 32'h0BADF00D);
    drive(1'b1, 1'b0, 3'b000, 32'h31, 32'hFFFFFFFF);
    @(negedge CLK);
    check("mis_we", {31'b0, WE}, 32'd0);
    check("mis_stall", {31'b0, StallM}, 32'd0);
    check("mis_fault_pre", {31'b0, AlignFault}, 32'd0);
    after_edge();
    check("mis_fault", {31'b0, AlignFault}, 32'd1);
    check("mis_mem", mem[12], 32'h0BADF00D);
    drive(1'b0, 1'b1, 3'b010, 32'h33, 32'h0);
    @(negedge CLK);
    check("mis_hload", ReadDataM, 32'h0);
    after_edge();
    drive(1'b1, 1'b0, 3'b010, 32'h31, 32'h1234);
    @(negedge CLK);
    check("mis_hst_stall", {31'b0, StallM}, 32'd0);
    check("mis_hst_we", {31'b0, WE}, 32'd0);
    after_edge();
    drive(1'b0, 1'b1, 3'b000, 32'h30, 32'h0);
    @(negedge CLK);
    check("mis_aligned_load", ReadDataM, 32'h0BADF00D);
    after_edge();
    check("mis_sticky", {31'b0, AlignFault}, 32'd1);

    // Reset during the RMW write cycle
    preload(6'd13, 32'h12345678);
    drive(1'b1, 1'b0, 3'b010, 32'h36, 32'h00009999);
    @(negedge CLK);
    check("rrmw_stall", {31'b0, StallM}, 32'd1);
    after_edge();
    @(negedge CLK);
    check("rrmw_we_pre", {31'b0, WE}, 32'd1);
    #1 Reset = 1'b0;
    #1;
    check("rrmw_we_drop", {31'b0, WE}, 32'd0);
    check("rrmw_stall_rst", {31'b0, StallM}, 32'd0);
    check("rrmw_fault_clr", {31'b0, AlignFault}, 32'd0);
    @(negedge CLK);
    check("rrmw_mem", mem[13], 32'h12345678);
    #2;
    drive(1'b0, 1'b0, 3'b010, 32'h36, 32'h0);
    Reset = 1'b1;
    #1;
    check("rrmw_idle_we", {31'b0, WE}, 32'd0);
    check("rrmw_idle_stall", {31'b0, StallM}, 32'd0);
    after_edge();

    // Back-to-back halfword stores
    preload(6'd16, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0000BEEF);
    @(negedge CLK);
    check("b2b_stall0", {31'b0, StallM}, 32'd1);
    after_edge();
    check("b2b_stall1", {31'b0, StallM}, 32'd0);
    check("b2b_wd1", WD, 32'h0000BEEF);
    after_edge();
    drive(1'b1, 1'b0, 3'b010, 32'h42, 32'h0000CAFE);
    @(negedge CLK);
    check("b2b_stall2", {31'b0, StallM}, 32'd1);
    after_edge();
    check("b2b_stall3", {31'b0, StallM}, 32'd0);
    check("b2b_wd3", WD, 32'hCAFEBEEF);
    after_edge();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("b2b_mem", mem[16], 32'hCAFEBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
